iterative_multiplier: RTL and testbench
=======================================

Name: iterative_multiplier

Overview:
- Configurable integer/fixed-point multiplier with a trigger/ready/done handshake, used by the synth datapath (e.g. envelope × oscillator sample).
- One RTL body with four selectable architectures (MUL_TYPE) that trade latency for area.
- All architectures produce bit-identical results.

Parameters:
- C_WIDTH, 32, operand and result width in bits; must be a multiple of 4 and at least 8.
- FIXED_POINT, 0, number of fractional bits; result = full product >> FIXED_POINT; must be in 0..C_WIDTH-1.
- MUL_TYPE, 0, architecture select, giving bits retired per iteration B:
  - 0: single-shot, B = C_WIDTH.
  - 1: radix-2 shift-add, B = 1.
  - 2: radix-4, B = 2.
  - 3: radix-16, B = 4.

Ports:
- ctl_clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  C_WIDTH  multiplicand, sampled at the start edge.
- b  in  C_WIDTH  multiplier, sampled at the start edge.
- signed_cal  in  1  1 = two's-complement operands, 0 = unsigned; sampled at the start edge.
- trigger  in  1  start request, level-sensitive.
- y  out  C_WIDTH  registered result.
- ready  out  1  high when idle and able to accept trigger.
- done  out  1  one-cycle pulse when y is updated.

Behaviour:
- Reset (reset=0, asynchronous): y=0, ready=1, done=0, FSM=IDLE, internal accumulators cleared.
- FSM states: IDLE, BUSY.
- IDLE, on an edge with trigger=1:
  - Capture a, b and signed_cal.
  - Go to BUSY; ready=0; load iteration counter N = C_WIDTH/B.
- trigger while ready=0 is ignored. No queuing; no change to the operation in progress.
- BUSY:
  - Each edge retires B bits of the multiplier magnitude: acc += (mcand_mag × next B bits) << position.
  - After the Nth BUSY edge, that same edge does all of the following:
    - y is updated.
    - done=1 for exactly one cycle.
    - ready=1.
    - FSM returns to IDLE.
- Latency, from the start edge to the edge at which y/done update:
  - C_WIDTH/B cycles.
  - MUL_TYPE 0: 1 cycle; 1: 32 cycles; 2: 16 cycles; 3: 8 cycles (32-bit).
- Back-to-back operation: if trigger is still high in the cycle after done, a new operation starts on that edge (ready is already 1). Maximum throughput is one result per N+1 cycles.
- Arithmetic:
  - signed_cal=1: take magnitudes of a and b (two's-complement negate if MSB set). Multiply unsigned to a 2·C_WIDTH product. Negate if sign(a) XOR sign(b).
  - signed_cal=0: plain unsigned product.
  - y = product[FIXED_POINT +: C_WIDTH]. Upper bits are truncated, with no overflow flag or saturation.
  - Most-negative operand (e.g. 0x80000000): the magnitude is computed in C_WIDTH+1 bits so the result is correct modulo 2^C_WIDTH.
- y holds its value between operations. Operand changes while BUSY do not affect the result.
- Reset asserted while BUSY aborts the operation: outputs return to reset values immediately, and y is not updated with a partial result.

Optional Feature:
- Macro ITERATIVE_MULTIPLIER_ROUND_EN.
- When defined and FIXED_POINT>0: add 2^(FIXED_POINT-1) to the full signed/unsigned product before the shift (round half up toward +inf).
- When undefined, or FIXED_POINT=0: plain truncation (floor for the final product).
- Latency is unchanged either way.

Decomposition:
- Package mul_pkg contains:
  - MUL_TYPE encoding constants MUL_SINGLE=0, MUL_R2=1, MUL_R4=2, MUL_R16=3.
  - Function bits_per_iter(MUL_TYPE).
  - FSM state typedef {IDLE, BUSY}.
- One sub-module, mul_step: combinational B-bit partial-product-and-accumulate slice, instantiated with width B.
- The top level holds the FSM, operand/sign capture, the counter and final negate/shift.

Test Plan:
- Reset held low then released → y=0x00000000, ready=1, done=0; trigger while reset=0 has no effect.
- C_WIDTH=32, FIXED_POINT=0, unsigned, a=0xEE6C3250, b=0x1BCA53C2, 1-cycle trigger → y=0xE56E10A0.
  - done pulses once.
  - Latency 1/32/16/8 cycles for MUL_TYPE 0/1/2/3; all four instances agree.
- Signed, a=0x00000005, b=0xFFFFFFFD → y=0xFFFFFFF1 (−15) for all MUL_TYPE. Same operands with signed_cal=0 → y=0xFFFFFFF1 (low word of the unsigned product).
- C_WIDTH=16, FIXED_POINT=8, signed:
  - 0x0180 × 0x0200 → y=0x0300.
  - 0xFE80 × 0x0200 → y=0xFD00.
  - 0x8000 × 0xFF00 (−128 × −1) → y=0x8000 (wrap).
- Trigger pulsed again mid-BUSY (MUL_TYPE=1) → ignored; original result delivered. Trigger held high → consecutive results every N+1 cycles.
- Reset asserted mid-BUSY → ready=1, done=0, y=0 immediately; next trigger completes normally.

Source files
------------

// File: rtl/iterative_multiplier_pkg.sv
// Shared constants, FSM state type and architecture helper for the iterative multiplier.
package mul_pkg;

    localparam int unsigned MUL_SINGLE = 0;
    localparam int unsigned MUL_R2     = 1;
    localparam int unsigned MUL_R4     = 2;
    localparam int unsigned MUL_R16    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Multiplier bits retired per BUSY cycle for a given architecture.
    function automatic int unsigned bits_per_iter(input int unsigned mul_type,
                                                  input int unsigned width);
        case (mul_type)
            MUL_R2:  return 1;
            MUL_R4:  return 2;
            MUL_R16: return 4;
            default: return width;
        endcase
    endfunction

endpackage

// File: rtl/iterative_multiplier_if.sv
// Operand, control and result bundle between a requester and the iterative multiplier.
interface iterative_multiplier_if #(
    parameter int unsigned C_WIDTH = 32
) ();

    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               signed_cal;
    logic               trigger;
    logic [C_WIDTH-1:0] y;
    logic               ready;
    logic               done;

    modport master (
        output a, b, signed_cal, trigger,
        input  y, ready, done
    );

    modport slave (
        input  a, b, signed_cal, trigger,
        output y, ready, done
    );

endinterface

// File: rtl/iterative_multiplier_mul_step.sv
// Combinational partial-product-and-accumulate slice: acc_o = acc_i + mcand_i * bits_i.
module mul_step #(
    parameter int unsigned AccWidth    = 64,
    parameter int unsigned BitsPerIter = 1
) (
    input  logic [AccWidth-1:0]    acc_i,
    input  logic [AccWidth-1:0]    mcand_i,
    input  logic [BitsPerIter-1:0] bits_i,
    output logic [AccWidth-1:0]    acc_o
);

    always_comb begin
        acc_o = acc_i + mcand_i * {{(AccWidth - BitsPerIter){1'b0}}, bits_i};
    end

endmodule

// File: rtl/iterative_multiplier.sv
// Iterative sign-magnitude multiplier with selectable radix (MUL_TYPE) and fixed-point shift.
// Optional round-half-up before the shift when ITERATIVE_MULTIPLIER_ROUND_EN is defined.
module iterative_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned FIXED_POINT = 0,
    parameter int unsigned MUL_TYPE    = 0
) (
    input logic                  ctl_clk,
    input logic                  reset,
    iterative_multiplier_if.slave bus
);

    localparam int unsigned B    = bits_per_iter(MUL_TYPE, C_WIDTH);
    localparam int unsigned N    = C_WIDTH / B;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned AccW = 2 * C_WIDTH;

`ifdef ITERATIVE_MULTIPLIER_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    localparam logic [AccW-1:0] RoundK = (RoundEn && FIXED_POINT > 0) ?
        (AccW'(1) << ((FIXED_POINT > 0) ? FIXED_POINT - 1 : 0)) : '0;

    state_e             state_q, state_d;
    logic [AccW-1:0]    mcand_q, mcand_d;
    logic [C_WIDTH:0]   mplier_q, mplier_d;
    logic [AccW-1:0]    acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [C_WIDTH-1:0] y_q, y_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [C_WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
    logic [AccW-1:0]    step_acc, prod, rounded;

    // One extra bit keeps the magnitude of the most negative operand exact.
    always_comb begin
        a_neg = bus.signed_cal & bus.a[C_WIDTH-1];
        b_neg = bus.signed_cal & bus.b[C_WIDTH-1];
        a_ext = {a_neg, bus.a};
        b_ext = {b_neg, bus.b};
        a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;
    end

    mul_step #(
        .AccWidth   (AccW),
        .BitsPerIter(B)
    ) u_step (
        .acc_i  (acc_q),
        .mcand_i(mcand_q),
        .bits_i (mplier_q[B-1:0]),
        .acc_o  (step_acc)
    );

    always_comb begin
        prod    = neg_q ? (~step_acc + 1'b1) : step_acc;
        rounded = prod + RoundK;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    state_d  = BUSY;
                    ready_d  = 1'b0;
                    mcand_d  = {{(AccW - C_WIDTH - 1){1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = CntW'(N);
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << B;
                mplier_d = mplier_q >> B;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    y_d     = C_WIDTH'(rounded >> FIXED_POINT);
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            y_q      <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Checks four 32-bit architectures and one 16-bit Q8 instance against a transaction-level model.
module tb_iterative_multiplier;

    logic        ctl_clk;
    logic        reset;
    logic [31:0] a32, b32;
    logic        s32, trig32;
    logic [15:0] a16, b16;
    logic        s16, trig16;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    iterative_multiplier_if #(.C_WIDTH(32)) if0 ();
    iterative_multiplier_if #(.C_WIDTH(32)) if1 ();
    iterative_multiplier_if #(.C_WIDTH(32)) if2 ();
    iterative_multiplier_if #(.C_WIDTH(32)) if3 ();
    iterative_multiplier_if #(.C_WIDTH(16)) if4 ();

    assign if0.a = a32; assign if0.b = b32; assign if0.signed_cal = s32; assign if0.trigger = trig32;
    assign if1.a = a32; assign if1.b = b32; assign if1.signed_cal = s32; assign if1.trigger = trig32;
    assign if2.a = a32; assign if2.b = b32; assign if2.signed_cal = s32; assign if2.trigger = trig32;
    assign if3.a = a32; assign if3.b = b32; assign if3.signed_cal = s32; assign if3.trigger = trig32;
    assign if4.a = a16; assign if4.b = b16; assign if4.signed_cal = s16; assign if4.trigger = trig16;

    iterative_multiplier #(.C_WIDTH(32), .FIXED_POINT(0), .MUL_TYPE(0)) u0 (
        .ctl_clk(ctl_clk), .reset(reset), .bus(if0));
    iterative_multiplier #(.C_WIDTH(32), .FIXED_POINT(0), .MUL_TYPE(1)) u1 (
        .ctl_clk(ctl_clk), .reset(reset), .bus(if1));
    iterative_multiplier #(.C_WIDTH(32), .FIXED_POINT(0), .MUL_TYPE(2)) u2 (
        .ctl_clk(ctl_clk), .reset(reset), .bus(if2));
    iterative_multiplier #(.C_WIDTH(32), .FIXED_POINT(0), .MUL_TYPE(3)) u3 (
        .ctl_clk(ctl_clk), .reset(reset), .bus(if3));
    iterative_multiplier #(.C_WIDTH(16), .FIXED_POINT(8), .MUL_TYPE(1)) u4 (
        .ctl_clk(ctl_clk), .reset(reset), .bus(if4));

    logic [31:0] dy[5];
    logic        dr[5];
    logic        dd[5];
    assign dy[0] = if0.y;  assign dr[0] = if0.ready; assign dd[0] = if0.done;
    assign dy[1] = if1.y;  assign dr[1] = if1.ready; assign dd[1] = if1.done;
    assign dy[2] = if2.y;  assign dr[2] = if2.ready; assign dd[2] = if2.done;
    assign dy[3] = if3.y;  assign dr[3] = if3.ready; assign dd[3] = if3.done;
    assign dy[4] = {16'h0, if4.y}; assign dr[4] = if4.ready; assign dd[4] = if4.done;

    int nlat[5] = '{1, 32, 16, 8, 16};

    bit          m_busy[5];
    bit          m_done[5];
    int          m_left[5];
    int          m_start[5];
    int          d_done[5];
    int          dcount[5];
    logic [31:0] m_res[5];
    logic [31:0] m_y[5];

    initial begin
        ctl_clk = 1'b0;
        forever #5 ctl_clk = ~ctl_clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [63:0] ea, eb, p;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        logic [31:0] ea, eb, p;
        ea = s ? {{16{a[15]}}, a} : {16'h0, a};
        eb = s ? {{16{b[15]}}, b} : {16'h0, b};
        p  = ea * eb;
`ifdef ITERATIVE_MULTIPLIER_ROUND_EN
        p  = p + 32'h80;
`endif
        return p[23:8];
    endfunction

    // Checker and cycle-level model: outputs are compared every negedge, then the model
    // advances to what the next rising edge must do with the inputs now applied.
    initial begin
        for (int k = 0; k < 5; k++) begin
            m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0; m_y[k] = '0; m_res[k] = '0;
            m_start[k] = 0; d_done[k] = -1; dcount[k] = 0;
        end
        forever begin
            @(negedge ctl_clk);
            cyc++;
            if (!reset) begin
                for (int k = 0; k < 5; k++) begin
                    m_busy[k] = 0; m_done[k] = 0; m_y[k] = '0;
                end
            end
            for (int k = 0; k < 5; k++) begin
                chk("y", k, dy[k], m_y[k]);
                chk("ready", k, {31'h0, dr[k]}, {31'h0, ~m_busy[k]});
                chk("done", k, {31'h0, dd[k]}, {31'h0, m_done[k]});
                if (dd[k] === 1'b1) begin
                    d_done[k] = cyc;
                    dcount[k]++;
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (reset) begin
                    m_done[k] = 0;
                    if (m_busy[k]) begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_y[k]    = m_res[k];
                            m_done[k] = 1;
                            m_busy[k] = 0;
                        end
                    end else if ((k < 4) ? trig32 : trig16) begin
                        m_busy[k]  = 1;
                        m_left[k]  = nlat[k];
                        m_res[k]   = (k < 4) ? ref32(a32, b32, s32) : {16'h0, ref16(a16, b16, s16)};
                        m_start[k] = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ctl_clk);
        #2;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 5; k++) begin
            d_done[k] = -1;
            dcount[k] = 0;
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s);
        clear_stats();
        step();
        a32 = a; b32 = b; s32 = s; trig32 = 1'b1;
        step();
        trig32 = 1'b0;
        repeat (36) begin
            step();
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
        clear_stats();
        step();
        a16 = a; b16 = b; s16 = s; trig16 = 1'b1;
        step();
        trig16 = 1'b0;
        repeat (20) begin
            step();
            a16 = 16'($urandom); b16 = 16'($urandom);
        end
    endtask

    task automatic lit32(input string nm, input logic [31:0] want);
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_y"}, k, dy[k], want);
            chk({nm, "_model"}, k, m_y[k], want);
            chk({nm, "_ndone"}, k, 32'(dcount[k]), 32'd1);
        end
    endtask

    initial begin
        int lat_lit[4] = '{1, 32, 16, 8};
        reset = 1'b0; trig32 = 1'b0; trig16 = 1'b0;
        a32 = '0; b32 = '0; s32 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;

        // Trigger under reset must do nothing.
        step();
        a32 = 32'h1234_5678; b32 = 32'h9; trig32 = 1'b1; a16 = 16'h0101; trig16 = 1'b1;
        repeat (4) step();
        chk("rst_y", 1, dy[1], 32'h0);
        chk("rst_ready", 3, {31'h0, dr[3]}, 32'h1);
        chk("rst_done", 0, {31'h0, dd[0]}, 32'h0);
        trig32 = 1'b0; trig16 = 1'b0; reset = 1'b1;
        repeat (2) step();

        run32(32'hEE6C_3250, 32'h1BCA_53C2, 1'b0);
        lit32("uns", 32'hE56E_10A0);
        for (int k = 0; k < 4; k++) chk("latency", k, 32'(d_done[k] - m_start[k]), 32'(lat_lit[k]));

        run32(32'h0000_0005, 32'hFFFF_FFFD, 1'b1);
        lit32("sgn", 32'hFFFF_FFF1);
        run32(32'h0000_0005, 32'hFFFF_FFFD, 1'b0);
        lit32("uns_lo", 32'hFFFF_FFF1);
        run32(32'h8000_0000, 32'h0000_0001, 1'b1);
        lit32("mostneg", 32'h8000_0000);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1);
        lit32("mostneg_sq", 32'h0000_0000);

        run16(16'h0180, 16'h0200, 1'b1);
        chk("q8_pos", 4, dy[4], 32'h0000_0300);
        chk("q8_lat", 4, 32'(d_done[4] - m_start[4]), 32'd16);
        run16(16'hFE80, 16'h0200, 1'b1);
        chk("q8_neg", 4, dy[4], 32'h0000_FD00);
        run16(16'h8000, 16'hFF00, 1'b1);
        chk("q8_wrap", 4, dy[4], 32'h0000_8000);

        // Re-trigger while busy: radix-2..16 must ignore it.
        clear_stats();
        step();
        a32 = 32'd3; b32 = 32'd7; s32 = 1'b0; trig32 = 1'b1;
        step();
        trig32 = 1'b0;
        repeat (5) step();
        trig32 = 1'b1;
        step();
        trig32 = 1'b0;
        repeat (34) step();
        for (int k = 1; k < 4; k++) begin
            chk("retrig_y", k, dy[k], 32'h0000_0015);
            chk("retrig_ndone", k, 32'(dcount[k]), 32'd1);
        end

        // Trigger held high: back-to-back results every N+1 cycles.
        clear_stats();
        step();
        trig32 = 1'b1; trig16 = 1'b1;
        repeat (120) begin
            step();
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
        end
        trig32 = 1'b0; trig16 = 1'b0;
        repeat (40) step();
        chk("b2b_ndone_r16", 3, 32'(dcount[3]), 32'd14);

        // Reset in the middle of an operation.
        step();
        a32 = 32'd9; b32 = 32'd9; s32 = 1'b0; trig32 = 1'b1;
        step();
        trig32 = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("abort_y", 1, dy[1], 32'h0);
        chk("abort_ready", 1, {31'h0, dr[1]}, 32'h1);
        chk("abort_done", 2, {31'h0, dd[2]}, 32'h0);
        step();
        reset = 1'b1;
        run32(32'd9, 32'd9, 1'b0);
        lit32("after_abort", 32'h0000_0051);

        repeat (12) begin
            run32($urandom, $urandom, 1'($urandom_range(0, 1)));
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
